hwpe_stream_sink_2d: RTL and testbench

Next-generation HWPE stream sink. It writes an incoming `DATA_WIDTH` stream into TCDM through `NB_TCDM_PORTS` 32-bit master ports, with 2D (line/stride) addressing and per-port partial-grant tracking. Unaligned realignment is out of scope: streams are word-aligned, and masking uses `strb`. It sits at the output of an HWPE datapath, replacing the linear sink in new engines.

---
 rtl/hwpe_stream_sink_2d_pkg.sv | 29 ++
 rtl/hwpe_stream_sink_2d_if.sv | 26 ++
 rtl/hwpe_stream_sink_2d_addrgen.sv | 107 ++++++++++
 rtl/hwpe_stream_sink_2d.sv | 133 +++++++++++++
 tb/tb_hwpe_stream_sink_2d.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_sink_2d_pkg.sv
// Shared types for the 2D HWPE stream sink: control/flag structs, FSM state
// encoding and the TCDM word size.
package hwpe_stream_package;

   localparam int unsigned TCDM_WORD_BYTES  = 4;
   localparam int unsigned SINK2D_LEN_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WORKING = 2'd1,
      DONE    = 2'd2
   } state_sink2d_t;

   typedef struct packed {
      logic                        req_start;
      logic [31:0]                 base_addr;
      logic [SINK2D_LEN_WIDTH-1:0] tot_len;
      logic [SINK2D_LEN_WIDTH-1:0] line_len;
      logic [31:0]                 line_stride;
   } ctrl_sink2d_t;

   typedef struct packed {
      logic                        ready_start;
      logic                        done;
      logic                        in_progress;
      logic [SINK2D_LEN_WIDTH-1:0] beat_cnt;
   } flags_sink2d_t;

endpackage

// File: rtl/hwpe_stream_sink_2d_if.sv
// TCDM write-port and stream interfaces used by the sink.
// Stream handshake: a beat transfers on a cycle where valid and ready are both 1;
// the source holds data/strb stable while valid=1 and ready=0.
interface hwpe_stream_intf_tcdm;
   logic        req;
   logic        gnt;
   logic        wen;
   logic [31:0] add;
   logic [3:0]  be;
   logic [31:0] data;

   modport master (output req, wen, add, be, data, input gnt);
   modport slave  (input req, wen, add, be, data, output gnt);
endinterface

interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 64
);
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport source (output valid, data, strb, input ready);
   modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_sink_2d_addrgen.sv
// Address and beat counter for the 2D sink. Line/stride support is present only
// when HWPE_STREAM_SINK_2D_EN is defined; otherwise addresses advance linearly.
module hwpe_stream_sink_addrgen_2d
   import hwpe_stream_package::*;
#(
   parameter int unsigned NB_TCDM_PORTS = 2,
   parameter int unsigned LEN_WIDTH     = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 i_load,
   input  logic                 i_en,
   input  logic [31:0]          i_base_addr,
   input  logic [LEN_WIDTH-1:0] i_tot_len,
   input  logic [LEN_WIDTH-1:0] i_line_len,
   input  logic [31:0]          i_line_stride,
   output logic [31:0]          o_cur_addr,
   output logic [LEN_WIDTH-1:0] o_beat_cnt,
   output logic                 o_last_beat
);

   localparam logic [31:0] BEAT_BYTES = 32'(NB_TCDM_PORTS * TCDM_WORD_BYTES);

   logic [31:0]          r_cur_addr;
   logic [LEN_WIDTH-1:0] r_beat_cnt;
   logic [LEN_WIDTH-1:0] r_tot_len;
   logic [LEN_WIDTH-1:0] w_beat_nxt;

   assign w_beat_nxt  = r_beat_cnt + LEN_WIDTH'(1);
   assign o_last_beat = (w_beat_nxt == r_tot_len);
   assign o_cur_addr  = r_cur_addr;
   assign o_beat_cnt  = r_beat_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_beat_cnt <= '0;
         r_tot_len  <= '0;
      end else if (clear_i) begin
         r_beat_cnt <= '0;
         r_tot_len  <= '0;
      end else if (i_load) begin
         r_beat_cnt <= '0;
         r_tot_len  <= i_tot_len;
      end else if (i_en) begin
         r_beat_cnt <= w_beat_nxt;
      end
   end

`ifdef HWPE_STREAM_SINK_2D_EN
   logic [31:0]          r_line_base;
   logic [31:0]          r_line_stride;
   logic [LEN_WIDTH-1:0] r_line_len;
   logic [LEN_WIDTH-1:0] r_word_idx;
   logic                 w_line_end;

   // line_len = 0 means one unbounded line, so the wrap never triggers
   assign w_line_end = (r_line_len != '0) && (r_word_idx == r_line_len - LEN_WIDTH'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cur_addr    <= '0;
         r_line_base   <= '0;
         r_line_stride <= '0;
         r_line_len    <= '0;
         r_word_idx    <= '0;
      end else if (clear_i) begin
         r_cur_addr    <= '0;
         r_line_base   <= '0;
         r_line_stride <= '0;
         r_line_len    <= '0;
         r_word_idx    <= '0;
      end else if (i_load) begin
         r_cur_addr    <= i_base_addr;
         r_line_base   <= i_base_addr;
         r_line_stride <= i_line_stride;
         r_line_len    <= i_line_len;
         r_word_idx    <= '0;
      end else if (i_en) begin
         if (w_line_end) begin
            r_word_idx  <= '0;
            r_line_base <= r_line_base + r_line_stride;
            r_cur_addr  <= r_line_base + r_line_stride;
         end else begin
            r_word_idx  <= r_word_idx + LEN_WIDTH'(1);
            r_cur_addr  <= r_cur_addr + BEAT_BYTES;
         end
      end
   end
`else
   logic w_unused_2d;
   assign w_unused_2d = ^{i_line_len, i_line_stride};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cur_addr <= '0;
      end else if (clear_i) begin
         r_cur_addr <= '0;
      end else if (i_load) begin
         r_cur_addr <= i_base_addr;
      end else if (i_en) begin
         r_cur_addr <= r_cur_addr + BEAT_BYTES;
      end
   end
`endif

endmodule

// File: rtl/hwpe_stream_sink_2d.sv
// HWPE stream sink writing word-aligned beats to TCDM over NB_TCDM_PORTS ports,
// tracking partial grants per port. Line/stride addressing: HWPE_STREAM_SINK_2D_EN.
module hwpe_stream_sink_2d
   import hwpe_stream_package::*;
#(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned NB_TCDM_PORTS = DATA_WIDTH / 32,
   parameter int unsigned LEN_WIDTH     = SINK2D_LEN_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   hwpe_stream_intf_tcdm.master   tcdm [NB_TCDM_PORTS-1:0],
   hwpe_stream_intf_stream.sink   stream,
   input  ctrl_sink2d_t           ctrl_i,
   output flags_sink2d_t          flags_o
);

   state_sink2d_t           r_state;
   logic                    r_ready_start;
   logic                    r_done;
   logic                    r_in_progress;
   logic [NB_TCDM_PORTS-1:0] r_granted;

   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic [NB_TCDM_PORTS-1:0] w_req, w_gnt, w_slice_nz, w_port_ok;
   logic                    w_working, w_load, w_beat_done, w_last_beat;
   logic [31:0]             w_cur_addr;
   logic [LEN_WIDTH-1:0]    w_beat_cnt;

   assign w_data    = stream.data;
   assign w_strb    = stream.strb;
   assign w_working = (r_state == WORKING);
   assign w_load    = (r_state == IDLE) && ctrl_i.req_start && !clear_i;

   for (genvar i = 0; i < NB_TCDM_PORTS; i++) begin : g_port
      assign w_slice_nz[i] = |w_strb[TCDM_WORD_BYTES*i +: TCDM_WORD_BYTES];
      assign w_req[i]      = w_working && stream.valid && w_slice_nz[i] && !r_granted[i];
      assign w_gnt[i]      = tcdm[i].gnt;
      // a port is finished with this beat once granted, or if it has nothing to write
      assign w_port_ok[i]  = r_granted[i] || (w_req[i] && w_gnt[i]) || !w_slice_nz[i];
      assign tcdm[i].req   = w_req[i];
      assign tcdm[i].wen   = 1'b0;
      assign tcdm[i].add   = w_cur_addr + 32'(TCDM_WORD_BYTES * i);
      assign tcdm[i].be    = w_strb[TCDM_WORD_BYTES*i +: TCDM_WORD_BYTES];
      assign tcdm[i].data  = w_data[32*i +: 32];
   end

   assign w_beat_done  = w_working && stream.valid && (&w_port_ok);
   assign stream.ready = w_beat_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state       <= IDLE;
         r_ready_start <= 1'b1;
         r_done        <= 1'b0;
         r_in_progress <= 1'b0;
         r_granted     <= '0;
      end else if (clear_i) begin
         r_state       <= IDLE;
         r_ready_start <= 1'b1;
         r_done        <= 1'b0;
         r_in_progress <= 1'b0;
         r_granted     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_granted <= '0;
               r_done    <= 1'b0;
               if (ctrl_i.req_start) begin
                  r_ready_start <= 1'b0;
                  if (ctrl_i.tot_len == '0) begin
                     r_state <= DONE;
                  end else begin
                     r_state       <= WORKING;
                     r_in_progress <= 1'b1;
                  end
               end
            end
            WORKING: begin
               if (w_beat_done) begin
                  r_granted <= '0;
                  if (w_last_beat) begin
                     r_state       <= DONE;
                     r_done        <= 1'b1;
                     r_in_progress <= 1'b0;
                  end
               end else begin
                  r_granted <= r_granted | (w_req & w_gnt);
               end
            end
            DONE: begin
               r_state       <= IDLE;
               r_ready_start <= 1'b1;
               // zero-length jobs reach DONE without a pulse; emit it on the way out
               r_done        <= !r_done;
            end
            default: begin
               r_state       <= IDLE;
               r_ready_start <= 1'b1;
               r_done        <= 1'b0;
               r_in_progress <= 1'b0;
               r_granted     <= '0;
            end
         endcase
      end
   end

   hwpe_stream_sink_addrgen_2d #(
      .NB_TCDM_PORTS (NB_TCDM_PORTS),
      .LEN_WIDTH     (LEN_WIDTH)
   ) i_addrgen (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .i_load        (w_load),
      .i_en          (w_beat_done),
      .i_base_addr   (ctrl_i.base_addr),
      .i_tot_len     (LEN_WIDTH'(ctrl_i.tot_len)),
      .i_line_len    (LEN_WIDTH'(ctrl_i.line_len)),
      .i_line_stride (ctrl_i.line_stride),
      .o_cur_addr    (w_cur_addr),
      .o_beat_cnt    (w_beat_cnt),
      .o_last_beat   (w_last_beat)
   );

   assign flags_o = '{ready_start: r_ready_start,
                      done:        r_done,
                      in_progress: r_in_progress,
                      beat_cnt:    SINK2D_LEN_WIDTH'(w_beat_cnt)};

endmodule

// File: tb/tb_hwpe_stream_sink_2d.sv
// Scoreboard bench for hwpe_stream_sink_2d: per-port expected-write queues filled
// by the stimulus tasks from an address model, drained by a negedge monitor.
module tb_hwpe_stream_sink_2d;
   import hwpe_stream_package::*;

   localparam int unsigned DW = 64;
   localparam int unsigned NB = 2;

   logic          clk_i   = 1'b0;
   logic          rst_ni  = 1'b0;
   logic          clear_i = 1'b0;
   ctrl_sink2d_t  ctrl_i;
   flags_sink2d_t flags_o;

   hwpe_stream_intf_tcdm tcdm [NB-1:0] ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) stream_if ();

   logic [NB-1:0] tb_req, tb_wen, tb_gnt;
   logic [NB-1:0] gnt_auto   = '1;
   logic [NB-1:0] gnt_manual = '0;
   int            gnt_mode   = 0;  // 0: always grant, 1: random, 2: manual
   logic [31:0]   tb_add  [NB];
   logic [3:0]    tb_be   [NB];
   logic [31:0]   tb_data [NB];

   for (genvar g = 0; g < NB; g++) begin : g_tap
      assign tb_req[g]    = tcdm[g].req;
      assign tb_wen[g]    = tcdm[g].wen;
      assign tb_add[g]    = tcdm[g].add;
      assign tb_be[g]     = tcdm[g].be;
      assign tb_data[g]   = tcdm[g].data;
      assign tcdm[g].gnt  = tb_gnt[g];
   end
   assign tb_gnt = (gnt_mode == 2) ? gnt_manual : gnt_auto;

   hwpe_stream_sink_2d #(
      .DATA_WIDTH    (DW),
      .NB_TCDM_PORTS (NB),
      .LEN_WIDTH     (16)
   ) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .tcdm    (tcdm),
      .stream  (stream_if),
      .ctrl_i  (ctrl_i),
      .flags_o (flags_o)
   );

   // clock/reset
   always #5 clk_i = ~clk_i;
   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;
   always @(posedge clk_i) begin
      #1;
      if (gnt_mode == 0) gnt_auto = '1;
      else               gnt_auto = 2'($urandom_range(0, 3));
   end

   // scoreboard: {addr, be, data} per port
   logic [67:0] exp_q0[$];
   logic [67:0] exp_q1[$];
   int errors = 0, checks = 0;
   int done_seen = 0, exp_done = 0;

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      logic [67:0] e;
      if (rst_ni) begin
         if (flags_o.done) done_seen++;
         for (int p = 0; p < NB; p++) begin
            if (stream_if.valid && stream_if.strb[4*p +: 4] == 4'h0)
               chk("masked_port_req", 68'(tb_req[p]), 68'(0));
            if (tb_req[p] && tb_gnt[p]) begin
               if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: port %0d got addr 0x%0h, expected no write", p, tb_add[p]);
               end else begin
                  if (p == 0) e = exp_q0.pop_front();
                  else        e = exp_q1.pop_front();
                  chk($sformatf("write_p%0d", p), {tb_add[p], tb_be[p], tb_data[p]}, e);
                  chk("wen_zero", 68'(tb_wen[p]), 68'(0));
               end
            end
         end
      end
   end

   // reference model: beat b lands at line*stride + word*beat_bytes from base
   function automatic logic [31:0] model_addr(input logic [31:0] base, input int b,
                                              input int ll, input logic [31:0] stride);
`ifdef HWPE_STREAM_SINK_2D_EN
      if (ll != 0)
         return base + 32'(b / ll) * stride + 32'(b % ll) * 32'(NB * 4);
`endif
      return base + 32'(b) * 32'(NB * 4);
   endfunction

   function automatic logic [7:0] pick_strb(input int mode);
      if (mode == 0) return 8'hFF;
      case ($urandom_range(0, 4))
         0:       return 8'hFF;
         1:       return 8'h0F;
         2:       return 8'hF0;
         3:       return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   // driver tasks
   task automatic wait_idle();
      int w = 0;
      @(negedge clk_i);
      while (!flags_o.ready_start && w < 500) begin
         w++;
         @(negedge clk_i);
      end
      if (!flags_o.ready_start) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got ready_start=0, expected 1");
      end
   endtask

   task automatic start_job(input logic [31:0] base, input int tot, input int ll,
                            input logic [31:0] stride);
      @(posedge clk_i); #1;
      ctrl_i.req_start   = 1'b1;
      ctrl_i.base_addr   = base;
      ctrl_i.tot_len     = 16'(tot);
      ctrl_i.line_len    = 16'(ll);
      ctrl_i.line_stride = stride;
      @(posedge clk_i); #1;
      // fields must have been latched at start
      ctrl_i.req_start   = 1'b0;
      ctrl_i.base_addr   = $urandom;
      ctrl_i.tot_len     = 16'($urandom);
      ctrl_i.line_len    = 16'($urandom);
      ctrl_i.line_stride = $urandom;
   endtask

   task automatic send_beat(input int b, input logic [63:0] d, input logic [7:0] s,
                            input logic [31:0] base, input int ll, input logic [31:0] stride);
      logic [31:0] a;
      int w = 0;
      a = model_addr(base, b, ll, stride);
      if (s[3:0] != 4'h0) exp_q0.push_back({a, s[3:0], d[31:0]});
      if (s[7:4] != 4'h0) exp_q1.push_back({a + 32'd4, s[7:4], d[63:32]});
      stream_if.valid = 1'b1;
      stream_if.data  = d;
      stream_if.strb  = s;
      @(negedge clk_i);
      while (!stream_if.ready && w < 200) begin
         w++;
         @(negedge clk_i);
      end
      if (!stream_if.ready) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: beat %0d got ready=0, expected 1", b);
      end
      if (s == 8'h00) chk("zero_strb_latency", 68'(w), 68'(0));
      @(posedge clk_i); #1;
   endtask

   task automatic run_job(input logic [31:0] base, input int tot, input int ll,
                          input logic [31:0] stride, input int strb_mode, input bit chk_rate);
      int s_cyc;
      wait_idle();
      start_job(base, tot, ll, stride);
      s_cyc = cyc;
      for (int b = 0; b < tot; b++)
         send_beat(b, {$urandom, $urandom}, pick_strb(strb_mode), base, ll, stride);
      stream_if.valid = 1'b0;
      if (chk_rate) chk("throughput_cycles", 68'(cyc - s_cyc), 68'(tot));
      @(negedge clk_i);
      chk("done_after_last", 68'(flags_o.done), 68'(1));
      chk("beat_cnt_final", 68'(flags_o.beat_cnt), 68'(tot));
      exp_done++;
   endtask

   initial begin
      logic [63:0] d;
      stream_if.valid = 1'b0;
      stream_if.data  = '0;
      stream_if.strb  = '0;
      ctrl_i          = '0;

      repeat (3) @(negedge clk_i);
      chk("rst_ready_start", 68'(flags_o.ready_start), 68'(1));
      chk("rst_done", 68'(flags_o.done), 68'(0));
      chk("rst_in_progress", 68'(flags_o.in_progress), 68'(0));
      chk("rst_beat_cnt", 68'(flags_o.beat_cnt), 68'(0));
      chk("rst_req", 68'(tb_req), 68'(0));
      chk("rst_stream_ready", 68'(stream_if.ready), 68'(0));
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // linear and 2D at full rate
      gnt_mode = 0;
      run_job(32'h1000, 4, 0, 32'h0, 0, 1'b1);
      run_job(32'h2000, 6, 3, 32'h100, 0, 1'b1);

      // strobe mask: half beat then empty beat
      wait_idle();
      start_job(32'h4000, 2, 0, 32'h0);
      d = {$urandom, $urandom};
      exp_q0.push_back({32'h4000, 4'hF, d[31:0]});
      stream_if.valid = 1'b1;
      stream_if.data  = d;
      stream_if.strb  = 8'h0F;
      @(negedge clk_i);
      chk("mask_req", 68'(tb_req), 68'(2'b01));
      chk("mask_be", 68'(tb_be[0]), 68'(4'hF));
      chk("mask_ready", 68'(stream_if.ready), 68'(1));
      @(posedge clk_i); #1;
      send_beat(1, {$urandom, $urandom}, 8'h00, 32'h4000, 0, 32'h0);
      stream_if.valid = 1'b0;
      @(negedge clk_i);
      chk("mask_done", 68'(flags_o.done), 68'(1));
      exp_done++;

      // partial grant: port 0 at t, port 1 at t+2
      wait_idle();
      gnt_mode   = 2;
      gnt_manual = 2'b00;
      start_job(32'h5000, 1, 0, 32'h0);
      d = {$urandom, $urandom};
      exp_q0.push_back({32'h5000, 4'hF, d[31:0]});
      exp_q1.push_back({32'h5004, 4'hF, d[63:32]});
      stream_if.valid = 1'b1;
      stream_if.data  = d;
      stream_if.strb  = 8'hFF;
      gnt_manual      = 2'b01;
      @(negedge clk_i);
      chk("pg_req_t0", 68'(tb_req), 68'(2'b11));
      chk("pg_ready_t0", 68'(stream_if.ready), 68'(0));
      @(posedge clk_i); #1;
      gnt_manual = 2'b00;
      @(negedge clk_i);
      chk("pg_req_t1", 68'(tb_req), 68'(2'b10));
      chk("pg_ready_t1", 68'(stream_if.ready), 68'(0));
      @(posedge clk_i); #1;
      gnt_manual = 2'b10;
      @(negedge clk_i);
      chk("pg_req_t2", 68'(tb_req), 68'(2'b10));
      chk("pg_ready_t2", 68'(stream_if.ready), 68'(1));
      @(posedge clk_i); #1;
      stream_if.valid = 1'b0;
      gnt_manual      = 2'b00;
      @(negedge clk_i);
      chk("pg_done", 68'(flags_o.done), 68'(1));
      exp_done++;
      gnt_mode = 0;

      // zero length: done two cycles after req_start
      wait_idle();
      start_job(32'h6000, 0, 0, 32'h0);
      @(negedge clk_i);
      chk("zl_done_c1", 68'(flags_o.done), 68'(0));
      @(negedge clk_i);
      chk("zl_done_c2", 68'(flags_o.done), 68'(1));
      exp_done++;

      // clear after 2 of 5 beats, then restart
      wait_idle();
      start_job(32'h7000, 5, 0, 32'h0);
      for (int b = 0; b < 2; b++)
         send_beat(b, {$urandom, $urandom}, 8'hFF, 32'h7000, 0, 32'h0);
      stream_if.valid = 1'b0;
      clear_i         = 1'b1;
      @(posedge clk_i); #1;
      clear_i = 1'b0;
      @(negedge clk_i);
      chk("clr_ready_start", 68'(flags_o.ready_start), 68'(1));
      chk("clr_in_progress", 68'(flags_o.in_progress), 68'(0));
      chk("clr_beat_cnt", 68'(flags_o.beat_cnt), 68'(0));
      chk("clr_done", 68'(flags_o.done), 68'(0));
      run_job(32'h3000, 3, 0, 32'h0, 0, 1'b1);

      // randomized jobs with random grants and strobes
      gnt_mode = 1;
      for (int j = 0; j < 8; j++)
         run_job($urandom & 32'hFFFF_FFFC, $urandom_range(1, 10), $urandom_range(0, 4),
                 $urandom & 32'h0000_FFFC, 1, 1'b0);
      gnt_mode = 0;

      wait_idle();
      repeat (4) @(negedge clk_i);
      chk("done_count", 68'(done_seen), 68'(exp_done));
      chk("q0_drained", 68'(exp_q0.size()), 68'(0));
      chk("q1_drained", 68'(exp_q1.size()), 68'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
